seq_detect_cfg: RTL

Parametrised serial pattern detector and the successor to the fixed 8-bit detector. It shifts a valid-qualified serial bit stream into a WIDTH-bit window and compares it against a runtime-loadable pattern with a per-bit compare mask. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits between a serial receiver front end and status/interrupt logic.

---
 rtl/seq_detect_pkg.sv | 18 +
 rtl/serial_window.sv | 24 ++
 rtl/seq_detect_cfg.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the configurable serial pattern detector.
package seq_detect_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int         DEFAULT_WIDTH   = 8;
    localparam logic [7:0] DEFAULT_PATTERN = 8'hD5;
    localparam int         DEFAULT_CNT_W   = 16;

    // Fill counter must be able to hold 0..WIDTH.
    function automatic int fill_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_window.sv
// WIDTH-bit left-shift window; window[WIDTH-1] holds the oldest bit.
module serial_window #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] window,
    output logic [WIDTH-1:0] window_next
);

    assign window_next = {window[WIDTH-2:0], din};

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            window <= '0;
        end else if (shift_en) begin
            window <= window_next;
        end
    end

endmodule

// File: rtl/seq_detect_cfg.sv
// Serial pattern detector with runtime pattern/mask, overlap mode and a
// saturating match counter.
module seq_detect_cfg #(
    parameter int               WIDTH           = seq_detect_pkg::DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(seq_detect_pkg::DEFAULT_PATTERN),
    parameter int               CNT_W           = seq_detect_pkg::DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             D_VALID,
    input  logic             D_IN,
    input  logic             CFG_LOAD,
    input  logic [WIDTH-1:0] CFG_PATTERN,
    input  logic [WIDTH-1:0] CFG_MASK,
    input  logic             CFG_OVERLAP,
    output logic             MATCH,
    output logic [CNT_W-1:0] MATCH_CNT
);

    import seq_detect_pkg::*;

    localparam int                FILL_W    = fill_w(WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

    logic [WIDTH-1:0]  pattern;
    logic [WIDTH-1:0]  mask;
    logic              overlap;
    logic [WIDTH-1:0]  window;
    logic [WIDTH-1:0]  window_next;
    logic              window_unused;
    state_t            state;
    state_t            state_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              accept;
    logic              hit;

    // A bit is only taken when no higher-priority command owns the cycle.
    assign accept = D_VALID && !CLR && !CFG_LOAD;

    serial_window #(
        .WIDTH(WIDTH)
    ) u_window (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clr        (CLR),
        .shift_en   (accept),
        .din        (D_IN),
        .window     (window),
        .window_next(window_next)
    );

    // The compare looks at the post-shift value; the registered window is observation only.
    assign window_unused = ^window;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pattern <= DEFAULT_PATTERN;
            mask    <= '1;
            overlap <= 1'b1;
        end else if (!CLR && CFG_LOAD) begin
            pattern <= CFG_PATTERN;
            mask    <= CFG_MASK;
            overlap <= CFG_OVERLAP;
        end
    end

    always_comb begin
        state_next = state;
        fill_next  = fill;
        hit        = 1'b0;
        if (CLR || CFG_LOAD) begin
            state_next = FILL;
            fill_next  = '0;
        end else if (D_VALID) begin
            if (state == ARMED || fill == FILL_LAST) begin
                hit = ((window_next ^ pattern) & mask) == '0;
                if (hit && !overlap) begin
                    state_next = FILL;
                    fill_next  = '0;
                end else begin
                    state_next = ARMED;
                end
            end else begin
                fill_next = fill + 1'b1;
            end
        end
    end

    // Match register stage: pulse and counter update on the accepting edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= FILL;
            fill      <= '0;
            MATCH     <= 1'b0;
            MATCH_CNT <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
            MATCH <= hit;
            if (CLR) begin
                MATCH_CNT <= '0;
            end else if (hit && MATCH_CNT != '1) begin
                MATCH_CNT <= MATCH_CNT + 1'b1;
            end
        end
    end

endmodule
